// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcode values, the opcode
// field position, and the fetch FSM state encoding.
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 13;

    localparam logic [2:0] OPC_MV  = 3'b000;
    localparam logic [2:0] OPC_MVI = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_SUB = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_OP  = 3'd1,
        S_WT_OP  = 3'd2,
        S_RD_IMM = 3'd3,
        S_WT_IMM = 3'd4,
        S_ISSUE  = 3'd5,
        S_EXEC   = 3'd6
    } fetch_state_t;

    function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_counter.sv
// Program counter: load has priority over increment; wraps modulo 2**ADDR_W.
module instr_fetch_unit_pc_counter #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads opcode (and mvi immediate) words from a
// synchronous ROM, issues them to the control unit and waits for done.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int         ADDR_W   = 8,
    parameter logic [2:0] OP_MVI   = OPC_MVI,
    parameter int         RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd,
    input  logic [15:0]        mem_data,
    output logic [15:0]        instr,
    output logic [15:0]        imm,
    output logic               new_instr,
    input  logic               done,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_load_val,
    output logic [ADDR_W-1:0]  pc
);

    fetch_state_t state, state_nxt;
    logic         pc_inc;
    logic         pc_ld;
    logic         op_cap;
    logic         imm_cap;
    logic         imm_clr;

    instr_fetch_unit_pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .inc      (pc_inc),
        .load     (pc_ld),
        .load_val (pc_load_val),
        .pc       (pc)
    );

    assign mem_addr = pc;

    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        new_instr = 1'b0;
        pc_inc    = 1'b0;
        pc_ld     = 1'b0;
        op_cap    = 1'b0;
        imm_cap   = 1'b0;
        imm_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) state_nxt = S_RD_OP;
            end
            S_RD_OP: begin
                mem_rd    = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = S_WT_OP;
            end
            S_WT_OP: begin
                op_cap = 1'b1;
                if (opcode_of(mem_data) == OP_MVI) begin
                    state_nxt = S_RD_IMM;
                end else begin
                    imm_clr   = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_RD_IMM: begin
                mem_rd    = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = S_WT_IMM;
            end
            S_WT_IMM: begin
                imm_cap   = 1'b1;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                new_instr = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                // Branch target only accepted together with completion of the instruction
                if (done) begin
                    pc_ld     = pc_load;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            instr <= '0;
            imm   <= '0;
        end else begin
            state <= state_nxt;
            if (op_cap)  instr <= mem_data;
            if (imm_cap) imm   <= mem_data;
            else if (imm_clr) imm <= '0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table of instructions fetched in sequence
// through a ROM model, plus hand sequences for handshake abuse and mid-op reset.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        run;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic [15:0] imm;
    logic        new_instr;
    logic        done;
    logic        pc_load;
    logic [7:0]  pc_load_val;
    logic [7:0]  pc;

    logic [15:0] rom [256];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  start_pc;
        logic [15:0] exp_instr;
        logic [15:0] exp_imm;
        int          exp_lat;
        logic [7:0]  exp_pc;
        int          done_dly;
        logic        do_load;
        logic [7:0]  load_val;
    } vec_t;

    vec_t vecs [8];

    instr_fetch_unit #(
        .ADDR_W   (8),
        .OP_MVI   (3'b001),
        .RESET_PC (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .instr       (instr),
        .imm         (imm),
        .new_instr   (new_instr),
        .done        (done),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .pc          (pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_rd) mem_data <= rom[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cnt;
        cnt = 0;
        while (!new_instr && cnt < 20) begin
            step();
            cnt++;
            if (cnt == 1) begin
                chk($sformatf("v%0d_first_rd", idx), mem_rd, 1);
                chk($sformatf("v%0d_first_addr", idx), mem_addr, v.start_pc);
            end
        end
        chk($sformatf("v%0d_latency", idx), cnt, v.exp_lat);
        chk($sformatf("v%0d_instr", idx), instr, v.exp_instr);
        chk($sformatf("v%0d_imm", idx), imm, v.exp_imm);
        chk($sformatf("v%0d_pc_issue", idx), pc, v.exp_pc);
        for (int i = 0; i < v.done_dly; i++) begin
            step();
            chk($sformatf("v%0d_no_dup", idx), new_instr, 0);
            chk($sformatf("v%0d_pc_hold", idx), pc, v.exp_pc);
        end
        done        = 1'b1;
        pc_load     = v.do_load;
        pc_load_val = v.load_val;
        step();
        done        = 1'b0;
        pc_load     = 1'b1;
        pc_load_val = 8'h77;
        chk($sformatf("v%0d_pc_after", idx), pc, v.do_load ? v.load_val : v.exp_pc);
        chk($sformatf("v%0d_idle_rd", idx), mem_rd, 0);
        chk($sformatf("v%0d_instr_held", idx), instr, v.exp_instr);
    endtask

    initial begin
        rst         = 1'b0;
        run         = 1'b0;
        done        = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = 8'h00;

        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[8'h00] = 16'h4000;
        rom[8'h01] = 16'h2000;
        rom[8'h02] = 16'h00A5;
        rom[8'h10] = 16'h0000;
        rom[8'h11] = 16'h3FFF;
        rom[8'h12] = 16'hFFFF;
        rom[8'h13] = 16'hE000;
        rom[8'h14] = 16'h4400;
        rom[8'h15] = 16'h5000;
        rom[8'h40] = 16'h6C80;
        rom[8'hFF] = 16'h2400;

        vecs[0] = '{8'h00, 16'h4000, 16'h0000, 3, 8'h01, 2, 1'b0, 8'h00};
        vecs[1] = '{8'h01, 16'h2000, 16'h00A5, 5, 8'h03, 1, 1'b1, 8'h40};
        vecs[2] = '{8'h40, 16'h6C80, 16'h0000, 3, 8'h41, 3, 1'b1, 8'hFF};
        vecs[3] = '{8'hFF, 16'h2400, 16'h4000, 5, 8'h01, 1, 1'b0, 8'h00};
        vecs[4] = '{8'h01, 16'h2000, 16'h00A5, 5, 8'h03, 2, 1'b1, 8'h10};
        vecs[5] = '{8'h10, 16'h0000, 16'h0000, 3, 8'h11, 1, 1'b0, 8'h00};
        vecs[6] = '{8'h11, 16'h3FFF, 16'hFFFF, 5, 8'h13, 1, 1'b0, 8'h00};
        vecs[7] = '{8'h13, 16'hE000, 16'h0000, 3, 8'h14, 1, 1'b0, 8'h00};

        #2;
        chk("rst_instr", instr, 16'h0000);
        chk("rst_imm", imm, 16'h0000);
        chk("rst_pc", pc, 8'h00);
        chk("rst_new_instr", new_instr, 0);
        chk("rst_mem_rd", mem_rd, 0);
        step();
        step();
        rst         = 1'b1;
        run         = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = 8'h77;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // done/pc_load in IDLE, run dropped during WT_OP, done in ISSUE
        done = 1'b1;
        step();
        chk("abuse_rd_op", mem_rd, 1);
        chk("abuse_addr", mem_addr, 8'h14);
        done = 1'b0;
        run  = 1'b0;
        step();
        chk("abuse_wt_rd", mem_rd, 0);
        chk("abuse_wt_new", new_instr, 0);
        step();
        chk("abuse_issue", new_instr, 1);
        chk("abuse_instr", instr, 16'h4400);
        chk("abuse_imm", imm, 16'h0000);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("abuse_exec_new", new_instr, 0);
        chk("abuse_issue_pc", pc, 8'h15);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abuse_exec_hold", new_instr, 0);
            chk("abuse_exec_rd", mem_rd, 0);
        end
        done    = 1'b1;
        pc_load = 1'b0;
        step();
        done    = 1'b0;
        pc_load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_rd", mem_rd, 0);
            chk("stall_new", new_instr, 0);
            chk("stall_pc", pc, 8'h15);
        end
        run = 1'b1;
        step();
        chk("resume_rd", mem_rd, 1);
        chk("resume_addr", mem_addr, 8'h15);

        // asynchronous reset while in EXEC
        step();
        step();
        chk("pre_rst_issue", new_instr, 1);
        chk("pre_rst_instr", instr, 16'h5000);
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_instr", instr, 16'h0000);
        chk("mid_rst_imm", imm, 16'h0000);
        chk("mid_rst_pc", pc, 8'h00);
        chk("mid_rst_addr", mem_addr, 8'h00);
        chk("mid_rst_rd", mem_rd, 0);
        chk("mid_rst_new", new_instr, 0);
        step();
        chk("in_rst_rd", mem_rd, 0);
        step();
        rst = 1'b1;
        step();
        chk("post_rst_rd", mem_rd, 1);
        chk("post_rst_addr", mem_addr, 8'h00);
        step();
        step();
        chk("post_rst_issue", new_instr, 1);
        chk("post_rst_instr", instr, 16'h4000);
        chk("post_rst_pc", pc, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
